// File: rtl/axil2iob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil2iob_pkg
//  Description : Shared definitions for the AXI4-Lite to native IOB bridge:
//                AXI response codes and the bridge FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil2iob_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_BRSP  = 3'd3,
    ST_RRSP  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axil2iob.sv
`default_nettype none
// ============================================================================
//  Module      : axil2iob
//  Description : AXI4-Lite slave to native single-strobe IOB master bridge.
//                AW, W and AR each land in a one-entry buffer; a small FSM
//                issues one native transaction at a time, alternating
//                between writes and reads when both are pending, and
//                returns SLVERR if the target never strobes ready.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    S_AXI_AW* / S_AXI_W*     write address / write data channels
//    S_AXI_B*                 write response channel
//    S_AXI_AR* / S_AXI_R*     read address / read data channels
//    valid                    native request strobe (held until ready/timeout)
//    addr, wdata, wstrb       native request payload (wstrb = 0 for reads)
//    rdata, ready             native completion data and 1-cycle strobe
// ============================================================================
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  // write address
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  // write data
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  // write response
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  // read address
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  // read data
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  // native master
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam int STRB_W = DATA_W / 8;

  // The timeout fires in the cycle where the counter would step onto
  // all-ones, so valid is high for exactly 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] TCNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t              state, state_nxt;
  logic                aw_full, w_full, ar_full;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                last_wr;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic aw_hs, w_hs, ar_hs;
  logic in_xfer;
  logic wr_pend, rd_pend;
  logic start_wr, start_rd, done_ok, done_to;

  // Protection attributes carry no meaning for the native side.
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Buffer readiness is masked during reset so nothing is accepted then.
  assign S_AXI_AWREADY = ~aw_full & ~rst;
  assign S_AXI_WREADY  = ~w_full  & ~rst;
  assign S_AXI_ARREADY = ~ar_full & ~rst;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  assign wr_pend = aw_full & w_full;
  assign rd_pend = ar_full;
  assign in_xfer = (state == ST_WRITE) || (state == ST_READ);

  assign valid = in_xfer;
  assign addr  = (state == ST_READ) ? ar_addr_q : aw_addr_q;
  assign wdata = w_data_q;
  assign wstrb = (state == ST_READ) ? '0 : w_strb_q;

  assign S_AXI_BVALID = (state == ST_BRSP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (state == ST_RRSP);
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        // On a tie, serve the type that was not served last.
        if (wr_pend && (!rd_pend || !last_wr)) begin
          state_nxt = ST_WRITE;
          start_wr  = 1'b1;
        end else if (rd_pend) begin
          state_nxt = ST_READ;
          start_rd  = 1'b1;
        end
      end
      ST_WRITE, ST_READ: begin
        if (ready) begin
          done_ok = 1'b1;
        end else if (tcnt == TCNT_LAST) begin
          done_to = 1'b1;
        end
        if (ready || (tcnt == TCNT_LAST)) begin
          state_nxt = (state == ST_WRITE) ? ST_BRSP : ST_RRSP;
        end
      end
      ST_BRSP: begin
        if (S_AXI_BREADY) state_nxt = ST_IDLE;
      end
      ST_RRSP: begin
        if (S_AXI_RREADY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, buffers, arbitration history, timeout counter and responses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      last_wr   <= 1'b0;
      tcnt      <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;

      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (ar_hs) begin
        ar_full   <= 1'b1;
        ar_addr_q <= S_AXI_ARADDR;
      end

      // Buffers are released only once the response has been taken.
      if ((state == ST_BRSP) && S_AXI_BREADY) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if ((state == ST_RRSP) && S_AXI_RREADY) begin
        ar_full <= 1'b0;
      end

      if (start_wr) last_wr <= 1'b1;
      if (start_rd) last_wr <= 1'b0;

      if (start_wr || start_rd) begin
        tcnt <= '0;
      end else if (in_xfer && !ready) begin
        tcnt <= tcnt + 1'b1;
      end

      if ((state == ST_WRITE) && (done_ok || done_to)) begin
        bresp_q <= done_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if ((state == ST_READ) && (done_ok || done_to)) begin
        rresp_q <= done_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= done_ok ? rdata : '0;
      end
    end
  end

endmodule
`default_nettype wire
